miyajiro_mem_arbiter: RTL and testbench
=======================================

# miyajiro_mem_arbiter

Shares the single-port, synchronous-read unified memory of the MIYAJIRO CPU between the instruction-fetch (IF) port and the data-memory (DM) load/store port. At most one request is issued per cycle. DM has priority, with a starvation limit that guarantees IF progress. Responses return in order at a fixed latency. A fetch flush discards stale instruction responses after a taken branch.

## Interface
- `ADDR_WIDTH`, default 15: word address width.
- `DATA_WIDTH`, default 32: word width; byte lanes = `DATA_WIDTH/8`.
- `READ_LATENCY`, default 1: memory read latency in cycles; legal range 1..4.
- `STARVE_LIMIT`, default 4: consecutive IF losses before IF is forced to win; legal range 1..15.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `if_req_valid`  in  1: fetch request.
- `if_req_ready`  out  1: fetch accepted this cycle.
- `if_addr`  in  `ADDR_WIDTH`: fetch word address.
- `if_flush`  in  1: drop in-flight fetch responses.
- `if_resp_valid`  out  1: fetch data valid.
- `if_resp_data`  out  `DATA_WIDTH`: fetched word.
- `dm_req_valid`  in  1: load/store request.
- `dm_req_ready`  out  1: load/store accepted.
- `dm_we`  in  1: 1 = store.
- `dm_addr`  in  `ADDR_WIDTH`: data word address.
- `dm_wdata`  in  `DATA_WIDTH`: store data.
- `dm_wstrb`  in  `DATA_WIDTH/8`: store byte enables.
- `dm_resp_valid`  out  1: load data or store acknowledge.
- `dm_resp_data`  out  `DATA_WIDTH`: load data; 0 for stores.
- `mem_en`  out  1: memory access strobe.
- `mem_we`  out  `DATA_WIDTH/8`: byte write enables.
- `mem_addr`  out  `ADDR_WIDTH`: memory address.
- `mem_wdata`  out  `DATA_WIDTH`: memory write data.
- `mem_rdata`  in  `DATA_WIDTH`: read data, valid `READ_LATENCY` cycles after `mem_en`.

## Operation
- **Accept rule.** A request is accepted when `valid && ready` at a rising edge. Ready is combinational from the valids and the starvation state. Valid must not depend on ready.
- **Grant.** DM wins when `dm_req_valid` is high, unless `starve_cnt == STARVE_LIMIT`. In that case IF wins and `dm_req_ready = 0`. IF wins whenever DM is idle.
- **starve_cnt** (4-bit register):
  - +1, saturating at `STARVE_LIMIT`, in cycles where both ports request and DM is granted.
  - Cleared when IF is granted or `if_req_valid` is low.
- **Memory drive.** `mem_en` = any grant. `mem_addr` and `mem_wdata` come from the winner. `mem_we` = `dm_wstrb` when a DM store is granted, else 0. All four are combinational in the grant cycle.
- **Tracker.** Each grant pushes a tag {valid, owner, is_store} into a `READ_LATENCY`-deep shift register. The tag at the output stage drives exactly one response:
  - owner IF: `if_resp_valid`, with `if_resp_data = mem_rdata`.
  - owner DM: `dm_resp_valid`, with `dm_resp_data` = `mem_rdata`, or 0 when is_store.
- **Response data.** Response data lines are 0 whenever their valid is low.
- **Flush.** `if_flush` high clears the valid bit of every IF tag already in the tracker, so those fetches never respond.
  - A fetch accepted in the same cycle as `if_flush` is not affected and responds normally.
  - DM tags are never affected by flush.
- **No response backpressure.** The CPU must take responses in the cycle they appear.
- **Reset** (asynchronous, at any time, including mid-operation):
  - Tracker cleared and `starve_cnt = 0`.
  - All outputs 0: ready, valid, `mem_en`, `mem_we`, data lines.
  - In-flight requests are lost and no responses are produced after reset.

## Timing
- Request to response is exactly `READ_LATENCY` cycles. With default 1: accept at edge T, response valid during cycle T+1.
- Throughput: one access per cycle, with back-to-back grants to any mix of owners.
- Responses are in grant order. At most one of `if_resp_valid` and `dm_resp_valid` is high per cycle.
- Worst-case IF wait under continuous DM traffic is `STARVE_LIMIT` cycles, followed by a grant on cycle `STARVE_LIMIT+1`.

## Structure
- Shared package `miyajiro_mem_pkg`:
  - `owner_t` enum: `OWN_IF`, `OWN_DM`.
  - `mem_tag_t` struct: valid, owner, is_store.
  - Default width constants.
- Sub-module `mem_resp_tracker`: tag shift register with push, flush-clear of IF tags, and output-stage decode.
- The top level holds the grant logic and starvation counter.

## Test plan
- **Reset.** Hold `reset_n = 0`, all inputs active. Required: all outputs 0. Release, then issue an IF read of 0x0010 while memory holds 0xDEADBEEF there. Required: `if_resp_valid` one cycle after accept, data 0xDEADBEEF.
- **Simultaneous requests.** IF 0x0004 and DM load 0x0100 in the same cycle. Required: DM granted at T and `dm_resp_valid` at T+1; IF granted at T+1 and responds at T+2.
- **Starvation.** DM requests continuously while IF holds 0x0008. Required: DM granted for 4 cycles, IF granted on the 5th with `dm_req_ready = 0`; the counter then clears and DM resumes.
- **Store.** DM store to 0x0020, data 0x11223344, `dm_wstrb = 0b0101`. Required: `mem_we = 0b0101` in the grant cycle, `dm_resp_valid` with data 0 at +1, and a subsequent load returning only bytes 0 and 2 updated.
- **Flush.** With `READ_LATENCY = 3`, accept fetches at cycles 0, 1 and 2, asserting `if_flush` in cycle 2. Required: only the cycle-2 fetch responds, at cycle 5.
- **Mid-operation reset.** Assert `reset_n = 0` with 2 requests in flight. Required: no response pulses after reset, and `starve_cnt = 0` on release.

Source files
------------

// File: rtl/miyajiro_mem_pkg.sv
// Shared types and default sizes for the MIYAJIRO unified-memory arbiter.
package miyajiro_mem_pkg;

   localparam int unsigned DEF_ADDR_WIDTH   = 15;
   localparam int unsigned DEF_DATA_WIDTH   = 32;
   localparam int unsigned DEF_READ_LATENCY = 1;
   localparam int unsigned DEF_STARVE_LIMIT = 4;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_t;

   // One in-flight access: who issued it and whether it was a store.
   typedef struct packed {
      logic   valid;
      owner_t owner;
      logic   is_store;
   } mem_tag_t;

endpackage

// File: rtl/mem_resp_tracker.sv
// Tag pipeline matching the memory read latency; the tag leaving the last
// stage steers mem_rdata to exactly one requester.
module mem_resp_tracker
   import miyajiro_mem_pkg::*;
#(
   parameter int unsigned DEPTH      = DEF_READ_LATENCY,
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  mem_tag_t              push_tag,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  if_resp_valid,
   output logic [DATA_WIDTH-1:0] if_resp_data,
   output logic                  dm_resp_valid,
   output logic [DATA_WIDTH-1:0] dm_resp_data
);

   mem_tag_t stage [DEPTH];
   mem_tag_t nxt   [DEPTH];
   mem_tag_t out_tag;

   // Next stage contents: new tag enters, older tags shift; flush kills only
   // IF tags already in flight, never the tag being pushed this cycle.
   always_comb begin
      nxt[0] = push_tag;
      for (int unsigned i = 1; i < DEPTH; i++) begin
         nxt[i] = stage[i-1];
         if (flush && (stage[i-1].owner == OWN_IF)) begin
            nxt[i].valid = 1'b0;
         end
      end
   end

   // Tag shift register, cleared asynchronously so nothing responds after reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            stage[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            stage[i] <= nxt[i];
         end
      end
   end

   assign out_tag = stage[DEPTH-1];

   // Output-stage decode: one response per valid tag, data zero when idle.
   always_comb begin
      if_resp_valid = out_tag.valid && (out_tag.owner == OWN_IF);
      dm_resp_valid = out_tag.valid && (out_tag.owner == OWN_DM);
      if_resp_data  = if_resp_valid ? mem_rdata : '0;
      dm_resp_data  = (dm_resp_valid && !out_tag.is_store) ? mem_rdata : '0;
   end

endmodule

// File: rtl/miyajiro_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// DM has priority; IF is forced through after STARVE_LIMIT consecutive losses.
module miyajiro_mem_arbiter
   import miyajiro_mem_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int unsigned READ_LATENCY = DEF_READ_LATENCY,
   parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    if_req_valid,
   output logic                    if_req_ready,
   input  logic [ADDR_WIDTH-1:0]   if_addr,
   input  logic                    if_flush,
   output logic                    if_resp_valid,
   output logic [DATA_WIDTH-1:0]   if_resp_data,
   input  logic                    dm_req_valid,
   output logic                    dm_req_ready,
   input  logic                    dm_we,
   input  logic [ADDR_WIDTH-1:0]   dm_addr,
   input  logic [DATA_WIDTH-1:0]   dm_wdata,
   input  logic [DATA_WIDTH/8-1:0] dm_wstrb,
   output logic                    dm_resp_valid,
   output logic [DATA_WIDTH-1:0]   dm_resp_data,
   output logic                    mem_en,
   output logic [DATA_WIDTH/8-1:0] mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   input  logic [DATA_WIDTH-1:0]   mem_rdata
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] starve_cnt;
   logic       if_forced;
   logic       dm_grant;
   logic       if_grant;
   mem_tag_t   push_tag;

   // Grant: DM first unless IF has waited LIMIT cycles; reset blocks all grants
   // so ready and memory strobes read zero while reset_n is low.
   always_comb begin
      if_forced = if_req_valid && (starve_cnt == LIMIT);
      dm_grant  = reset_n && dm_req_valid && !if_forced;
      if_grant  = reset_n && if_req_valid && !dm_grant;
   end

   // Memory drive, readies and the tracker tag all follow the grant this cycle.
   always_comb begin
      if_req_ready      = if_grant;
      dm_req_ready      = dm_grant;
      mem_en            = dm_grant || if_grant;
      mem_we            = (dm_grant && dm_we) ? dm_wstrb : '0;
      mem_addr          = dm_grant ? dm_addr : (if_grant ? if_addr : '0);
      mem_wdata         = dm_grant ? dm_wdata : '0;
      push_tag.valid    = dm_grant || if_grant;
      push_tag.owner    = dm_grant ? OWN_DM : OWN_IF;
      push_tag.is_store = dm_grant && dm_we;
   end

   // Consecutive IF losses to DM; an IF grant or an idle IF clears it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         starve_cnt <= '0;
      end else if (!if_req_valid || if_grant) begin
         starve_cnt <= '0;
      end else if (dm_grant && (starve_cnt != LIMIT)) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end

   mem_resp_tracker #(
      .DEPTH      (READ_LATENCY),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_tracker (
      .clk           (clk),
      .reset_n       (reset_n),
      .push_tag      (push_tag),
      .flush         (if_flush),
      .mem_rdata     (mem_rdata),
      .if_resp_valid (if_resp_valid),
      .if_resp_data  (if_resp_data),
      .dm_resp_valid (dm_resp_valid),
      .dm_resp_data  (dm_resp_data)
   );

endmodule

// File: tb/tb_miyajiro_mem_arbiter.sv
// Bench for miyajiro_mem_arbiter: two instances (latency 1 and 3) share the
// request inputs, each with its own memory; a cycle-calendar model checks both.
module tb_miyajiro_mem_arbiter;

   localparam int unsigned LIM = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        if_req_valid;
   logic [14:0] if_addr;
   logic        if_flush;
   logic        dm_req_valid;
   logic        dm_we;
   logic [14:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [3:0]  dm_wstrb;

   logic        if_rdy [2];
   logic        dm_rdy [2];
   logic        ifr_v  [2];
   logic        dmr_v  [2];
   logic        m_en   [2];
   logic [3:0]  m_we   [2];
   logic [14:0] m_addr [2];
   logic [31:0] m_wd   [2];
   logic [31:0] m_rd   [2];
   logic [31:0] ifr_d  [2];
   logic [31:0] dmr_d  [2];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   miyajiro_mem_arbiter #(.READ_LATENCY(1), .STARVE_LIMIT(LIM)) dut0 (
      .clk(clk), .reset_n(reset_n),
      .if_req_valid(if_req_valid), .if_req_ready(if_rdy[0]), .if_addr(if_addr), .if_flush(if_flush),
      .if_resp_valid(ifr_v[0]), .if_resp_data(ifr_d[0]),
      .dm_req_valid(dm_req_valid), .dm_req_ready(dm_rdy[0]), .dm_we(dm_we), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb),
      .dm_resp_valid(dmr_v[0]), .dm_resp_data(dmr_d[0]),
      .mem_en(m_en[0]), .mem_we(m_we[0]), .mem_addr(m_addr[0]), .mem_wdata(m_wd[0]), .mem_rdata(m_rd[0])
   );

   miyajiro_mem_arbiter #(.READ_LATENCY(3), .STARVE_LIMIT(LIM)) dut1 (
      .clk(clk), .reset_n(reset_n),
      .if_req_valid(if_req_valid), .if_req_ready(if_rdy[1]), .if_addr(if_addr), .if_flush(if_flush),
      .if_resp_valid(ifr_v[1]), .if_resp_data(ifr_d[1]),
      .dm_req_valid(dm_req_valid), .dm_req_ready(dm_rdy[1]), .dm_we(dm_we), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb),
      .dm_resp_valid(dmr_v[1]), .dm_resp_data(dmr_d[1]),
      .mem_en(m_en[1]), .mem_we(m_we[1]), .mem_addr(m_addr[1]), .mem_wdata(m_wd[1]), .mem_rdata(m_rd[1])
   );

   function automatic int unsigned lat(int d);
      return (d == 0) ? 1 : 3;
   endfunction

   function automatic logic [31:0] f_init(int unsigned a);
      if (a == 32'h10) return 32'hDEADBEEF;
      return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // ---------------- memories (one per DUT) ----------------
   logic [31:0] mem    [2][32768];
   logic [31:0] shadow [2][32768];
   logic [31:0] pipe   [2][4];

   initial begin
      for (int a = 0; a < 32768; a++) begin
         for (int d = 0; d < 2; d++) begin
            mem[d][a]    = f_init(a);
            shadow[d][a] = f_init(a);
         end
      end
      for (int d = 0; d < 2; d++)
         for (int k = 0; k < 4; k++) pipe[d][k] = '0;
   end

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         for (int k = 3; k > 0; k--) pipe[d][k] = pipe[d][k-1];
         if (m_en[d]) begin
            pipe[d][0] = mem[d][m_addr[d]];
            for (int b = 0; b < 4; b++)
               if (m_we[d][b]) mem[d][m_addr[d]][8*b +: 8] = m_wd[d][8*b +: 8];
         end else begin
            pipe[d][0] = $urandom;
         end
      end
   end

   assign m_rd[0] = pipe[0][0];
   assign m_rd[1] = pipe[1][2];

   // ---------------- reference model: calendar of due responses ----------------
   int unsigned cyc_n  = 0;
   int unsigned losses = 0;
   logic        cal_v  [2][16];
   logic        cal_dm [2][16];
   logic [31:0] cal_d  [2][16];
   logic        g_dm, g_if, e_ifv, e_dmv;
   logic [31:0] e_ifd, e_dmd;
   int unsigned s, s2;

   initial begin
      for (int d = 0; d < 2; d++)
         for (int k = 0; k < 16; k++) begin
            cal_v[d][k] = 1'b0; cal_dm[d][k] = 1'b0; cal_d[d][k] = '0;
         end
   end

   always @(negedge clk) begin
      g_dm = reset_n && dm_req_valid && !(if_req_valid && losses == LIM);
      g_if = reset_n && if_req_valid && !g_dm;
      s = cyc_n % 16;
      for (int d = 0; d < 2; d++) begin
         e_ifv = reset_n && cal_v[d][s] && !cal_dm[d][s];
         e_dmv = reset_n && cal_v[d][s] && cal_dm[d][s];
         e_ifd = e_ifv ? cal_d[d][s] : 32'h0;
         e_dmd = e_dmv ? cal_d[d][s] : 32'h0;
         chk($sformatf("m%0d c%0d if_req_ready", d, cyc_n), if_rdy[d], g_if);
         chk($sformatf("m%0d c%0d dm_req_ready", d, cyc_n), dm_rdy[d], g_dm);
         chk($sformatf("m%0d c%0d mem_en", d, cyc_n), m_en[d], g_dm || g_if);
         chk($sformatf("m%0d c%0d mem_we", d, cyc_n), m_we[d], (g_dm && dm_we) ? dm_wstrb : 4'h0);
         if (g_dm || g_if || !reset_n)
            chk($sformatf("m%0d c%0d mem_addr", d, cyc_n), m_addr[d],
                g_dm ? dm_addr : (g_if ? if_addr : 15'h0));
         if ((g_dm && dm_we) || !reset_n)
            chk($sformatf("m%0d c%0d mem_wdata", d, cyc_n), m_wd[d], g_dm ? dm_wdata : 32'h0);
         chk($sformatf("m%0d c%0d if_resp_valid", d, cyc_n), ifr_v[d], e_ifv);
         chk($sformatf("m%0d c%0d if_resp_data", d, cyc_n), ifr_d[d], e_ifd);
         chk($sformatf("m%0d c%0d dm_resp_valid", d, cyc_n), dmr_v[d], e_dmv);
         chk($sformatf("m%0d c%0d dm_resp_data", d, cyc_n), dmr_d[d], e_dmd);
         cal_v[d][s] = 1'b0;
         if (!reset_n) begin
            for (int k = 0; k < 16; k++) cal_v[d][k] = 1'b0;
         end else begin
            if (if_flush)
               for (int unsigned k = 1; k < lat(d); k++) begin
                  s2 = (cyc_n + k) % 16;
                  if (!cal_dm[d][s2]) cal_v[d][s2] = 1'b0;
               end
            if (g_dm || g_if) begin
               s2 = (cyc_n + lat(d)) % 16;
               cal_v[d][s2]  = 1'b1;
               cal_dm[d][s2] = g_dm;
               cal_d[d][s2]  = (g_dm && dm_we) ? 32'h0 : shadow[d][g_dm ? dm_addr : if_addr];
            end
            if (g_dm && dm_we)
               for (int b = 0; b < 4; b++)
                  if (dm_wstrb[b]) shadow[d][dm_addr][8*b +: 8] = dm_wdata[8*b +: 8];
         end
      end
      if (!reset_n || !if_req_valid || g_if) losses = 0;
      else if (g_dm && losses < LIM) losses++;
      cyc_n++;
   end

   // ---------------- directed stimulus ----------------
   typedef struct {
      logic        if_v;
      logic [14:0] if_a;
      logic        dm_v;
      logic        dm_w;
      logic [14:0] dm_a;
      logic [31:0] dm_wd;
      logic [3:0]  dm_ws;
      logic        e_if_rdy;
      logic        e_dm_rdy;
      logic        e_en;
      logic [3:0]  e_we;
      logic [14:0] e_addr;
   } vec_t;

   vec_t tbl [9];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic iv, input logic [14:0] ia, input logic dv, input logic dw,
                        input logic [14:0] da, input logic [31:0] dwd, input logic [3:0] dws,
                        input logic fl);
      if_req_valid = iv; if_addr = ia; dm_req_valid = dv; dm_we = dw;
      dm_addr = da; dm_wdata = dwd; dm_wstrb = dws; if_flush = fl;
   endtask

   task automatic idle();
      drive(1'b0, 15'h0, 1'b0, 1'b0, 15'h0, 32'h0, 4'h0, 1'b0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] w;
      tbl[0] = '{1'b0, 15'h0,   1'b0, 1'b0, 15'h0,   32'h0,        4'h0, 1'b0, 1'b0, 1'b0, 4'h0, 15'h0};
      tbl[1] = '{1'b1, 15'h4,   1'b0, 1'b0, 15'h0,   32'h0,        4'h0, 1'b1, 1'b0, 1'b1, 4'h0, 15'h4};
      tbl[2] = '{1'b0, 15'h0,   1'b1, 1'b0, 15'h100, 32'h0,        4'h0, 1'b0, 1'b1, 1'b1, 4'h0, 15'h100};
      tbl[3] = '{1'b1, 15'h4,   1'b1, 1'b0, 15'h101, 32'h0,        4'h0, 1'b0, 1'b1, 1'b1, 4'h0, 15'h101};
      tbl[4] = '{1'b1, 15'h5,   1'b0, 1'b0, 15'h0,   32'h0,        4'h0, 1'b1, 1'b0, 1'b1, 4'h0, 15'h5};
      tbl[5] = '{1'b0, 15'h0,   1'b1, 1'b1, 15'h30,  32'hAABBCCDD, 4'hF, 1'b0, 1'b1, 1'b1, 4'hF, 15'h30};
      tbl[6] = '{1'b1, 15'h6,   1'b1, 1'b1, 15'h31,  32'h12345678, 4'h8, 1'b0, 1'b1, 1'b1, 4'h8, 15'h31};
      tbl[7] = '{1'b0, 15'h0,   1'b1, 1'b0, 15'h40,  32'hFFFFFFFF, 4'hF, 1'b0, 1'b1, 1'b1, 4'h0, 15'h40};
      tbl[8] = '{1'b1, 15'h7,   1'b1, 1'b0, 15'h41,  32'h0,        4'h0, 1'b0, 1'b1, 1'b1, 4'h0, 15'h41};

      // Reset held with every input active: all outputs must be zero.
      reset_n = 1'b0;
      drive(1'b1, 15'h10, 1'b1, 1'b1, 15'h22, 32'hFFFFFFFF, 4'hF, 1'b1);
      repeat (2) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst d%0d if_req_ready", d), if_rdy[d], 1'b0);
            chk($sformatf("rst d%0d dm_req_ready", d), dm_rdy[d], 1'b0);
            chk($sformatf("rst d%0d mem_en", d), m_en[d], 1'b0);
            chk($sformatf("rst d%0d mem_we", d), m_we[d], 4'h0);
            chk($sformatf("rst d%0d mem_addr", d), m_addr[d], 15'h0);
            chk($sformatf("rst d%0d mem_wdata", d), m_wd[d], 32'h0);
            chk($sformatf("rst d%0d resp_valids", d), {ifr_v[d], dmr_v[d]}, 2'b00);
            chk($sformatf("rst d%0d resp_data", d), ifr_d[d] | dmr_d[d], 32'h0);
         end
      end
      tick();

      // First fetch after release.
      reset_n = 1'b1;
      drive(1'b1, 15'h10, 1'b0, 1'b0, 15'h0, 32'h0, 4'h0, 1'b0);
      @(negedge clk);
      chk("first_fetch if_req_ready", if_rdy[0], 1'b1);
      tick();
      idle();
      @(negedge clk);
      chk("first_fetch if_resp_valid", ifr_v[0], 1'b1);
      chk("first_fetch if_resp_data", ifr_d[0], 32'hDEADBEEF);
      tick();

      // Simultaneous IF and DM load.
      drive(1'b1, 15'h4, 1'b1, 1'b0, 15'h100, 32'h0, 4'h0, 1'b0);
      @(negedge clk);
      chk("simul T dm_req_ready", dm_rdy[0], 1'b1);
      chk("simul T if_req_ready", if_rdy[0], 1'b0);
      chk("simul T mem_addr", m_addr[0], 15'h100);
      tick();
      drive(1'b1, 15'h4, 1'b0, 1'b0, 15'h0, 32'h0, 4'h0, 1'b0);
      @(negedge clk);
      chk("simul T+1 dm_resp_valid", dmr_v[0], 1'b1);
      chk("simul T+1 dm_resp_data", dmr_d[0], f_init(32'h100));
      chk("simul T+1 if_req_ready", if_rdy[0], 1'b1);
      chk("simul T+1 mem_addr", m_addr[0], 15'h4);
      tick();
      idle();
      @(negedge clk);
      chk("simul T+2 if_resp_valid", ifr_v[0], 1'b1);
      chk("simul T+2 if_resp_data", ifr_d[0], f_init(32'h4));
      tick();

      // Table of single-cycle grant vectors.
      for (int i = 0; i < 9; i++) begin
         drive(tbl[i].if_v, tbl[i].if_a, tbl[i].dm_v, tbl[i].dm_w, tbl[i].dm_a,
               tbl[i].dm_wd, tbl[i].dm_ws, 1'b0);
         @(negedge clk);
         chk($sformatf("tbl%0d if_req_ready", i), if_rdy[0], tbl[i].e_if_rdy);
         chk($sformatf("tbl%0d dm_req_ready", i), dm_rdy[0], tbl[i].e_dm_rdy);
         chk($sformatf("tbl%0d mem_en", i), m_en[0], tbl[i].e_en);
         chk($sformatf("tbl%0d mem_we", i), m_we[0], tbl[i].e_we);
         if (tbl[i].e_en) chk($sformatf("tbl%0d mem_addr", i), m_addr[0], tbl[i].e_addr);
         tick();
      end

      // Partial-strobe store then reload.
      drive(1'b0, 15'h0, 1'b1, 1'b1, 15'h20, 32'h11223344, 4'b0101, 1'b0);
      @(negedge clk);
      chk("store mem_we", m_we[0], 4'b0101);
      chk("store mem_wdata", m_wd[0], 32'h11223344);
      chk("store dm_req_ready", dm_rdy[0], 1'b1);
      tick();
      drive(1'b0, 15'h0, 1'b1, 1'b0, 15'h20, 32'h0, 4'h0, 1'b0);
      @(negedge clk);
      chk("store ack dm_resp_valid", dmr_v[0], 1'b1);
      chk("store ack dm_resp_data", dmr_d[0], 32'h0);
      tick();
      idle();
      w = f_init(32'h20);
      @(negedge clk);
      chk("reload dm_resp_valid", dmr_v[0], 1'b1);
      chk("reload dm_resp_data", dmr_d[0], {w[31:24], 8'h22, w[15:8], 8'h44});
      tick();

      // Starvation: DM continuous, IF forced through every fifth cycle.
      for (int k = 1; k <= 10; k++) begin
         drive(1'b1, (k <= 5) ? 15'h8 : 15'hC, 1'b1, 1'b0, 15'(32'h200 + k), 32'h0, 4'h0, 1'b0);
         @(negedge clk);
         chk($sformatf("starve k%0d if_req_ready", k), if_rdy[0], (k % 5) == 0);
         chk($sformatf("starve k%0d dm_req_ready", k), dm_rdy[0], (k % 5) != 0);
         if (k == 5) chk("starve k5 mem_addr", m_addr[0], 15'h8);
         tick();
      end
      idle();
      repeat (4) tick();

      // Flush on the latency-3 instance.
      for (int c = 0; c < 3; c++) begin
         drive(1'b1, 15'(c + 1), 1'b0, 1'b0, 15'h0, 32'h0, 4'h0, c == 2);
         tick();
      end
      idle();
      for (int j = 3; j <= 6; j++) begin
         @(negedge clk);
         chk($sformatf("flush c%0d if_resp_valid", j), ifr_v[1], j == 5);
         if (j == 5) chk("flush c5 if_resp_data", ifr_d[1], f_init(32'h3));
         tick();
      end
      repeat (2) tick();

      // Mid-operation reset with requests in flight and starvation built up.
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 15'h9, 1'b1, 1'b0, 15'(32'h300 + k), 32'h0, 4'h0, 1'b0);
         tick();
      end
      reset_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("midrst k%0d d%0d resp_valids", k, d), {ifr_v[d], dmr_v[d]}, 2'b00);
            chk($sformatf("midrst k%0d d%0d mem_en", k, d), m_en[d], 1'b0);
         end
         tick();
      end
      reset_n = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         drive(1'b1, 15'h9, 1'b1, 1'b0, 15'(32'h310 + k), 32'h0, 4'h0, 1'b0);
         @(negedge clk);
         chk($sformatf("postrst k%0d dm_req_ready", k), dm_rdy[0], k < 5);
         chk($sformatf("postrst k%0d if_req_ready", k), if_rdy[0], k == 5);
         if (k <= 2) chk($sformatf("postrst k%0d d1 resp_valids", k), {ifr_v[1], dmr_v[1]}, 2'b00);
         tick();
      end

      // Randomized traffic checked by the model.
      for (int n = 0; n < 3000; n++) begin
         reset_n      = ($urandom_range(0, 299) != 0);
         if_req_valid = ($urandom_range(0, 9) < 6);
         if_addr      = 15'($urandom_range(0, 31));
         if_flush     = ($urandom_range(0, 9) == 0);
         dm_req_valid = ($urandom_range(0, 9) < 6);
         dm_we        = ($urandom_range(0, 9) < 3);
         dm_addr      = 15'($urandom_range(0, 31));
         dm_wdata     = $urandom;
         dm_wstrb     = 4'($urandom);
         tick();
      end
      reset_n = 1'b1;
      idle();
      repeat (6) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
